// File: rtl/exp_range_reduce_if.sv
// Sample bus of exp_range_reduce: argument in, CORDIC head and aligned tail out.
// Master drives the argument; slave (the reducer) drives everything else.
interface exp_range_reduce_if #(
   parameter int DATA_WIDTH = 32,
   parameter int K_WIDTH    = 6
);
   logic                         in_valid;
   logic signed [DATA_WIDTH-1:0] x_in;
   logic                         cordic_valid;
   logic signed [DATA_WIDTH-1:0] cordic_x;
   logic signed [DATA_WIDTH-1:0] cordic_y;
   logic signed [DATA_WIDTH-1:0] cordic_z;
   logic                         tail_valid;
   logic signed [K_WIDTH-1:0]    tail_k;
   logic                         tail_ovf;
   logic                         tail_unf;

   modport master (
      output in_valid, x_in,
      input  cordic_valid, cordic_x, cordic_y, cordic_z,
      input  tail_valid, tail_k, tail_ovf, tail_unf
   );

   modport slave (
      input  in_valid, x_in,
      output cordic_valid, cordic_x, cordic_y, cordic_z,
      output tail_valid, tail_k, tail_ovf, tail_unf
   );
endinterface

// File: rtl/exp_range_reduce.sv
// Range reduction x = k*ln2 + r for the hyperbolic-CORDIC exp path.
// Optional clamping and ovf/unf flags are enabled by EXP_RANGE_CLAMP_EN.
module exp_range_reduce #(
   parameter int DATA_WIDTH = 32,
   parameter int K_WIDTH    = 6,
   parameter int CORDIC_LAT = 16,
   parameter logic signed [DATA_WIDTH-1:0] LN2     = 32'sd45426,
   parameter logic signed [DATA_WIDTH-1:0] INV_LN2 = 32'sd94548,
   parameter logic signed [DATA_WIDTH-1:0] INV_KH  = 32'sd79134,
   parameter logic signed [DATA_WIDTH-1:0] X_MAX   = 32'sd681376,
   parameter logic signed [DATA_WIDTH-1:0] X_MIN   = -32'sd726817
) (
   input logic              clk,
   input logic              rst,
   exp_range_reduce_if.slave bus
);
   localparam int PW = 2 * DATA_WIDTH;
   localparam int RW = DATA_WIDTH + K_WIDTH;
   localparam logic signed [K_WIDTH-1:0] K_ONE = 1;

   typedef struct packed {
      logic                      v;
      logic signed [K_WIDTH-1:0] k;
      logic                      ovf;
      logic                      unf;
   } tail_t;

   logic signed [DATA_WIDTH-1:0] xc_d;
   logic                         ovf_d, unf_d;

   logic                         s1_v, s1_ovf, s1_unf;
   logic signed [DATA_WIDTH-1:0] s1_xc;
   logic signed [PW-1:0]         s1_p;

   logic signed [K_WIDTH-1:0]    k0_d;
   logic signed [RW-1:0]         kl, r0w;
   logic                         s2_v, s2_ovf, s2_unf;
   logic signed [DATA_WIDTH-1:0] s2_r;
   logic signed [K_WIDTH-1:0]    s2_k;

   logic signed [DATA_WIDTH-1:0] r_d;
   logic signed [K_WIDTH-1:0]    k_d;
   logic                         s3_v, s3_ovf, s3_unf;
   logic signed [DATA_WIDTH-1:0] s3_r;
   logic signed [K_WIDTH-1:0]    s3_k;

   tail_t s3_t, tl;

   // Invalid samples are zeroed here so every downstream field reads 0.
   always_comb begin
      xc_d  = bus.x_in;
      ovf_d = 1'b0;
      unf_d = 1'b0;
`ifdef EXP_RANGE_CLAMP_EN
      if (bus.x_in > X_MAX) begin
         xc_d  = X_MAX;
         ovf_d = 1'b1;
      end else if (bus.x_in < X_MIN) begin
         xc_d  = X_MIN;
         unf_d = 1'b1;
      end
`endif
      if (!bus.in_valid) begin
         xc_d  = '0;
         ovf_d = 1'b0;
         unf_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_v   <= 1'b0;
         s1_ovf <= 1'b0;
         s1_unf <= 1'b0;
         s1_xc  <= '0;
         s1_p   <= '0;
      end else begin
         s1_v   <= bus.in_valid;
         s1_ovf <= ovf_d;
         s1_unf <= unf_d;
         s1_xc  <= xc_d;
         s1_p   <= xc_d * INV_LN2;
      end
   end

   // Integer part of the Q32.32 product is floor(x/ln2), possibly off by one.
   assign k0_d = s1_p[DATA_WIDTH +: K_WIDTH];
   assign kl   = k0_d * LN2;
   assign r0w  = s1_xc - kl;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_v   <= 1'b0;
         s2_ovf <= 1'b0;
         s2_unf <= 1'b0;
         s2_r   <= '0;
         s2_k   <= '0;
      end else begin
         s2_v   <= s1_v;
         s2_ovf <= s1_ovf;
         s2_unf <= s1_unf;
         s2_r   <= r0w[DATA_WIDTH-1:0];
         s2_k   <= k0_d;
      end
   end

   always_comb begin
      r_d = s2_r;
      k_d = s2_k;
      if (s2_r[DATA_WIDTH-1]) begin
         r_d = s2_r + LN2;
         k_d = s2_k - K_ONE;
      end else if (s2_r >= LN2) begin
         r_d = s2_r - LN2;
         k_d = s2_k + K_ONE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s3_v   <= 1'b0;
         s3_ovf <= 1'b0;
         s3_unf <= 1'b0;
         s3_r   <= '0;
         s3_k   <= '0;
      end else begin
         s3_v   <= s2_v;
         s3_ovf <= s2_ovf;
         s3_unf <= s2_unf;
         s3_r   <= r_d;
         s3_k   <= k_d;
      end
   end

   assign bus.cordic_valid = s3_v;
   assign bus.cordic_x     = s3_v ? INV_KH : '0;
   assign bus.cordic_y     = '0;
   assign bus.cordic_z     = s3_r;

   assign s3_t = '{v: s3_v, k: s3_k, ovf: s3_ovf, unf: s3_unf};

   generate
      if (CORDIC_LAT == 0) begin : g_pass
         assign tl = s3_t;
      end else begin : g_dly
         tail_t dly [CORDIC_LAT];
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int i = 0; i < CORDIC_LAT; i++) dly[i] <= '0;
            end else begin
               dly[0] <= s3_t;
               for (int i = 1; i < CORDIC_LAT; i++) dly[i] <= dly[i-1];
            end
         end
         assign tl = dly[CORDIC_LAT-1];
      end
   endgenerate

   assign bus.tail_valid = tl.v;
   assign bus.tail_k     = tl.k;
   assign bus.tail_ovf   = tl.ovf;
   assign bus.tail_unf   = tl.unf;

   logic unused_p;
   assign unused_p = ^{s1_p[PW-1:RW], s1_p[DATA_WIDTH-1:0]};
`ifndef EXP_RANGE_CLAMP_EN
   logic unused_cfg;
   assign unused_cfg = ^{X_MAX, X_MIN};
`endif
endmodule

// File: tb/tb_exp_range_reduce.sv
// Bench for exp_range_reduce: floor-division model, directed literals,
// random stream with bubbles and a mid-stream reset.
module tb_exp_range_reduce;
   localparam int LAT = 16;
   localparam longint LN2  = 45426;
   localparam longint XMAX = 681376;
   localparam longint XMIN = -726817;
   localparam logic [31:0] INVKH = 32'd79134;

   typedef struct packed {
      logic        v;
      logic [31:0] x;
      logic [31:0] y;
      logic [31:0] z;
   } cor_t;

   typedef struct packed {
      logic       v;
      logic [5:0] k;
      logic       ovf;
      logic       unf;
   } tl_t;

   logic clk = 1'b0;
   logic rst;
   int   ntest = 0;
   int   nfail = 0;
   int   cyc = 0;
   int   last_rst = 0;
   logic stim_v [0:4095];
   int   stim_x [0:4095];

   exp_range_reduce_if #(.DATA_WIDTH(32), .K_WIDTH(6)) bus ();

   exp_range_reduce #(.CORDIC_LAT(LAT)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // Exact integer decomposition: k = floor(xc/ln2), r = xc - k*ln2.
   function automatic void model(input logic v, input int x,
                                 output cor_t c, output tl_t t);
      longint xc, q, r;
      logic [63:0] qb;
      c = '0;
      t = '0;
      if (v) begin
         xc = longint'(x);
`ifdef EXP_RANGE_CLAMP_EN
         if (xc > XMAX) begin xc = XMAX; t.ovf = 1'b1; end
         else if (xc < XMIN) begin xc = XMIN; t.unf = 1'b1; end
`endif
         q = xc / LN2;
         if ((xc % LN2) < 0) q = q - 1;
         r = xc - q * LN2;
         qb = q;
         c.v = 1'b1;
         c.x = INVKH;
         c.z = r[31:0];
         t.v = 1'b1;
         t.k = qb[5:0];
      end
   endfunction

   always @(posedge clk) begin
      cyc = cyc + 1;
      stim_v[cyc] = bus.in_valid;
      stim_x[cyc] = bus.x_in;
      if (rst) last_rst = cyc;
   end

   always @(negedge clk) begin
      cor_t ec, ac, dc;
      tl_t  et, at, dt;
      int   j;
      if (cyc > 0) begin
         ac = '{bus.cordic_valid, bus.cordic_x, bus.cordic_y, bus.cordic_z};
         at = '{bus.tail_valid, bus.tail_k, bus.tail_ovf, bus.tail_unf};
         ec = '0;
         et = '0;
         if (!rst) begin
            j = cyc - 2;
            if (j > last_rst) model(stim_v[j], stim_x[j], ec, dt);
            j = cyc - 2 - LAT;
            if (j > last_rst) model(stim_v[j], stim_x[j], dc, et);
         end
         ntest++;
         if (ac !== ec) begin
            nfail++;
            $display("FAIL cordic cyc=%0d got v=%0b x=%0d y=%0d z=%0d want v=%0b x=%0d y=%0d z=%0d",
                     cyc, ac.v, ac.x, ac.y, $signed(ac.z), ec.v, ec.x, ec.y, $signed(ec.z));
         end
         ntest++;
         if (at !== et) begin
            nfail++;
            $display("FAIL tail cyc=%0d got v=%0b k=%0d o=%0b u=%0b want v=%0b k=%0d o=%0b u=%0b",
                     cyc, at.v, $signed(at.k), at.ovf, at.unf,
                     et.v, $signed(et.k), et.ovf, et.unf);
         end
      end
   end

   task automatic pin(input string nm, input int x, input int z, input int k,
                      input logic ovf, input logic unf);
      cor_t c;
      tl_t  t;
      model(1'b1, x, c, t);
      ntest++;
      if ($signed(c.z) != z || $signed(t.k) != k || t.ovf != ovf || t.unf != unf) begin
         nfail++;
         $display("FAIL model_%s got z=%0d k=%0d o=%0b u=%0b want z=%0d k=%0d o=%0b u=%0b",
                  nm, $signed(c.z), $signed(t.k), t.ovf, t.unf, z, k, ovf, unf);
      end
   endtask

   task automatic pulse(input string nm, input int x, input int z, input int k);
      @(posedge clk);
      #2 bus.in_valid = 1'b1; bus.x_in = x;
      @(posedge clk);
      #2 bus.in_valid = 1'b0; bus.x_in = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      ntest++;
      if (bus.cordic_z !== z || bus.cordic_x !== INVKH || bus.cordic_y !== 0) begin
         nfail++;
         $display("FAIL head_%s got z=%0d x=%0d y=%0d want z=%0d x=%0d y=0",
                  nm, bus.cordic_z, bus.cordic_x, bus.cordic_y, z, INVKH);
      end
      repeat (LAT) @(posedge clk);
      @(negedge clk);
      ntest++;
      if (bus.tail_k !== 6'(k) || bus.tail_valid !== 1'b1) begin
         nfail++;
         $display("FAIL tail_%s got k=%0d v=%0b want k=%0d v=1",
                  nm, bus.tail_k, bus.tail_valid, k);
      end
   endtask

   task automatic drive(input logic v, input int x);
      @(posedge clk);
      #2 bus.in_valid = v; bus.x_in = x;
   endtask

   task automatic stream(input int nvalid, input int lo, input int hi);
      int n = 0;
      while (n < nvalid) begin
         if ($urandom_range(3) != 0) begin
            drive(1'b1, lo + int'($urandom_range(hi - lo)));
            n++;
         end else begin
            drive(1'b0, 0);
         end
      end
      drive(1'b0, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at cyc=%0d", cyc);
      $display("[TB] %0d tests run, %0d failed", ntest, nfail + 1);
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      bus.in_valid = 1'b0;
      bus.x_in = 0;
      pin("zero", 0, 0, 0, 1'b0, 1'b0);
      pin("one", 65536, 20110, 1, 1'b0, 1'b0);
      pin("mone", -65536, 25316, -2, 1'b0, 1'b0);
      pin("ln2", 45426, 0, 1, 1'b0, 1'b0);
      pin("xmin", -726817, 45425, -17, 1'b0, 1'b0);
`ifdef EXP_RANGE_CLAMP_EN
      pin("big", 786432, 45412, 14, 1'b1, 1'b0);
      pin("small", -1048576, 45425, -17, 1'b0, 1'b1);
`else
      pin("xmax", 681376, 45412, 14, 1'b0, 1'b0);
`endif
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      pulse("zero", 0, 0, 0);
      pulse("one", 65536, 20110, 1);
      pulse("mone", -65536, 25316, -2);
      pulse("ln2", 45426, 0, 1);
      pulse("ln2m1", 45425, 45425, 0);
      pulse("xmax", 681376, 45412, 14);
      pulse("xmin", -726817, 45425, -17);
`ifdef EXP_RANGE_CLAMP_EN
      pulse("big", 786432, 45412, 14);
      pulse("small", -1048576, 45425, -17);
`endif
      drive(1'b1, 681376);
      drive(1'b1, -726817);
      drive(1'b1, -1);
      drive(1'b1, 1);
`ifdef EXP_RANGE_CLAMP_EN
      stream(20, -2000000, 2000000);
`else
      stream(20, -726817, 681376);
`endif
      repeat (LAT + 4) drive(1'b0, 0);
      stream(8, -726817, 681376);
      drive(1'b1, 131072);
      #1 rst = 1'b1;
      drive(1'b1, 65536);
      drive(1'b0, 0);
      rst = 1'b0;
      repeat (LAT + 6) drive(1'b0, 0);
      stream(6, -726817, 681376);
      repeat (LAT + 4) drive(1'b0, 0);
      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", ntest, nfail);
      $finish;
   end
endmodule
